// File: rtl/add_sched_pkg.sv
// Shared definitions for the add_sched adder-sharing scheduler:
// FSM state encoding, default settle window and a settle-sizing helper.
package add_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SETTLE_DEFAULT = 3;
    localparam int NOR_DELAY_PS   = 2000;

    // Cycles needed to cover a ripple path of 'depth' NOR levels at period clk_ps.
    function automatic int settle_cycles(input int depth, input int clk_ps);
        return (depth * NOR_DELAY_PS + clk_ps - 1) / clk_ps;
    endfunction

endpackage

// File: rtl/add_sched_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr,
// wrapping around, reported one-hot and as an encoded index.
module rr_pick #(
    parameter int NREQ = 4,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_vec,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW-1:0] cand;

    assign any = |req;

    // Scan from the farthest offset back to ptr so the nearest requester wins.
    always_comb begin
        idx  = '0;
        cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

    always_comb begin
        gnt_vec = '0;
        if (any) begin
            gnt_vec[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/add_sched.sv
// Round-robin scheduler sharing one external ripple adder among NREQ requesters;
// operands are held for SETTLE cycles before the sum is captured and returned.
module add_sched
    import add_sched_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NREQ   = 4,
    parameter int SETTLE = SETTLE_DEFAULT,
    localparam int IW    = $clog2(NREQ),
    localparam int CW    = $clog2(SETTLE + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    input  logic [NREQ-1:0]       cin_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    input  logic [WIDTH-1:0]      add_s,
    input  logic                  add_cout,
    output logic                  res_valid,
    output logic [IW-1:0]         res_id,
    output logic [WIDTH-1:0]      res_sum,
    output logic                  res_cout
);

    state_e            state_q;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     ptr_d;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     cur_id_q;
    logic              busy_q;
    logic [WIDTH-1:0]  add_a_q;
    logic [WIDTH-1:0]  add_b_q;
    logic              add_cin_q;
    logic              res_valid_q;
    logic [IW-1:0]     res_id_q;
    logic [WIDTH-1:0]  res_sum_q;
    logic              res_cout_q;

    logic [NREQ-1:0]   pick_vec;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic [WIDTH-1:0]  add_a_d;
    logic [WIDTH-1:0]  add_b_d;
    logic              add_cin_d;

    rr_pick #(
        .NREQ(NREQ)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_vec (pick_vec),
        .idx     (pick_idx),
        .any     (pick_any)
    );

    // Grant is only offered from IDLE, so nothing is accepted while the adder is in use.
    assign gnt = (state_q == IDLE && !rst) ? pick_vec : '0;

    always_comb begin
        add_a_d   = a_in[int'(pick_idx) * WIDTH +: WIDTH];
        add_b_d   = b_in[int'(pick_idx) * WIDTH +: WIDTH];
        add_cin_d = cin_in[pick_idx];
        ptr_d     = (int'(cur_id_q) == NREQ - 1) ? '0 : cur_id_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            cur_id_q    <= '0;
            busy_q      <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        add_a_q   <= add_a_d;
                        add_b_q   <= add_b_d;
                        add_cin_q <= add_cin_d;
                        cur_id_q  <= pick_idx;
                        cnt_q     <= CW'(SETTLE - 1);
                        busy_q    <= 1'b1;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    // The adder inputs have been stable for SETTLE cycles when cnt reaches zero.
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        res_sum_q   <= add_s;
                        res_cout_q  <= add_cout;
                        res_id_q    <= cur_id_q;
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    ptr_q   <= ptr_d;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;

`ifndef SYNTHESIS
    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_gnt_idle:   assert property (@(posedge clk) disable iff (rst) (gnt != '0) |-> (state_q == IDLE));
`endif

endmodule

// File: tb/tb_add_sched.sv
// Bench for add_sched: directed scenarios with literal expectations plus random
// traffic, all checked every cycle against a transaction-level model.
module tb_add_sched;
    import add_sched_pkg::*;

    localparam int WIDTH  = 16;
    localparam int NREQ   = 4;
    localparam int SETTLE = SETTLE_DEFAULT;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       cin_in;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic                  add_cin;
    logic [WIDTH-1:0]      add_s;
    logic                  add_cout;
    logic                  res_valid;
    logic [1:0]            res_id;
    logic [WIDTH-1:0]      res_sum;
    logic                  res_cout;

    int n_checks = 0;
    int n_errors = 0;

    add_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin_in    (cin_in),
        .gnt       (gnt),
        .busy      (busy),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_sum   (res_sum),
        .res_cout  (res_cout)
    );

    always #5 clk = ~clk;

    // Shared adder stand-in: its output is corrupted until the inputs have been
    // stable long enough, so sampling too early yields a wrong sum.
    logic [2*WIDTH:0] last_ops = '0;
    int               age = 0;
    logic [WIDTH:0]   raw_sum;

    always @(posedge clk) begin
        if ({add_a, add_b, add_cin} !== last_ops) begin
            last_ops <= {add_a, add_b, add_cin};
            age      <= 1;
        end else if (age < 1000) begin
            age <= age + 1;
        end
    end

    always_comb begin
        raw_sum  = add_a + add_b + add_cin;
        add_s    = (age >= SETTLE - 1) ? raw_sum[WIDTH-1:0] : (raw_sum[WIDTH-1:0] ^ 16'hA5A5);
        add_cout = (age >= SETTLE - 1) ? raw_sum[WIDTH] : ~raw_sum[WIDTH];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    int               m_ptr = 0;
    int               m_phase = 0;   // 0 idle, 1..SETTLE holding, SETTLE+1 result cycle
    int               m_id = 0;
    logic [WIDTH-1:0] m_a = '0, m_b = '0;
    logic             m_cin = 1'b0;
    int               m_res_id = 0;
    logic [WIDTH-1:0] m_res_sum = '0;
    logic             m_res_cout = 1'b0;
    int               m_win;

    always_comb m_win = pick(req, m_ptr);

    always @(posedge clk) begin
        if (rst) begin
            m_ptr <= 0; m_phase <= 0; m_id <= 0;
            m_a <= '0; m_b <= '0; m_cin <= 1'b0;
            m_res_id <= 0; m_res_sum <= '0; m_res_cout <= 1'b0;
        end else if (m_phase == 0) begin
            if (m_win >= 0) begin
                m_a     <= a_in[m_win*WIDTH +: WIDTH];
                m_b     <= b_in[m_win*WIDTH +: WIDTH];
                m_cin   <= cin_in[m_win];
                m_id    <= m_win;
                m_phase <= 1;
            end
        end else if (m_phase <= SETTLE) begin
            if (m_phase == SETTLE) begin
                {m_res_cout, m_res_sum} <= m_a + m_b + m_cin;
                m_res_id <= m_id;
            end
            m_phase <= m_phase + 1;
        end else begin
            m_ptr   <= (m_id + 1) % NREQ;
            m_phase <= 0;
        end
    end

    // Single compare process, mid-cycle.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_gnt;
        exp_gnt = '0;
        if (!rst && m_phase == 0 && m_win >= 0) exp_gnt[m_win] = 1'b1;
        chk("gnt",       gnt,       exp_gnt);
        chk("busy",      busy,      m_phase != 0);
        chk("res_valid", res_valid, m_phase == SETTLE + 1);
        chk("add_a",     add_a,     m_a);
        chk("add_b",     add_b,     m_b);
        chk("add_cin",   add_cin,   m_cin);
        chk("res_id",    res_id,    m_res_id);
        chk("res_sum",   res_sum,   m_res_sum);
        chk("res_cout",  res_cout,  m_res_cout);
    end

    // ---------------- stimulus ----------------
    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        a_in[i*WIDTH +: WIDTH] = a;
        b_in[i*WIDTH +: WIDTH] = b;
        cin_in[i] = c;
    endtask

    task automatic wait_res(output logic [1:0] id, output logic [WIDTH-1:0] s, output logic c);
        id = '0; s = '0; c = 1'b0;
        for (int k = 0; k < 20; k++) begin
            nc();
            #1;
            if (res_valid === 1'b1) begin
                id = res_id; s = res_sum; c = res_cout;
                return;
            end
        end
        chk("res_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) nc();
        rst = 1'b0;
    endtask

    logic [1:0]       r_id;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    int               order[5];
    int               ng;

    initial begin
        rst = 1'b1; req = '0; a_in = '0; b_in = '0; cin_in = '0;
        repeat (2) nc();
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_res_sum", res_sum, 0);
        chk("rst_res_id", res_id, 0);

        // Single request with exact timing
        nc();
        req = 4'b0100;
        set_op(2, 16'h1234, 16'h0F0F, 1'b1);
        #1;
        chk("single_gnt", gnt, 4'b0100);
        nc();
        req = '0;
        repeat (SETTLE - 1) nc();
        #1;
        chk("single_early_valid", res_valid, 0);
        nc();
        #1;
        chk("single_valid", res_valid, 1);
        chk("single_id", res_id, 2);
        chk("single_sum", res_sum, 16'h2144);
        chk("single_cout", res_cout, 0);
        nc();

        // Round-robin fairness from ptr=0
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 16'h1111 * (i + 1) + 16'h0005, 16'h0F00 * (i + 1), i[0]);
        req = 4'b1111;
        ng = 0;
        for (int k = 0; k < 60 && ng < 5; k++) begin
            #1;
            if (gnt != '0) begin
                for (int j = 0; j < NREQ; j++) if (gnt[j]) order[ng] = j;
                ng++;
            end
            nc();
            if (ng == 5) req = '0;
        end
        chk("rr_count", ng, 5);
        chk("rr_0", order[0], 0);
        chk("rr_1", order[1], 1);
        chk("rr_2", order[2], 2);
        chk("rr_3", order[3], 3);
        chk("rr_4", order[4], 0);
        wait_res(r_id, r_sum, r_cout);
        chk("rr_last_id", r_id, 0);
        nc();

        // Carry out and wrap to zero
        req = 4'b0010;
        set_op(1, 16'hFFFF, 16'h0001, 1'b0);
        #1;
        chk("carry_gnt", gnt, 4'b0010);
        nc();
        req = '0;
        wait_res(r_id, r_sum, r_cout);
        chk("carry_sum", r_sum, 16'h0000);
        chk("carry_cout", r_cout, 1);
        chk("carry_id", r_id, 1);
        nc();

        // Pointer wrap and skip
        do_reset();
        set_op(0, 16'h0A0A, 16'h0101, 1'b0);
        set_op(2, 16'h0C0C, 16'h0303, 1'b1);
        set_op(3, 16'h0D0D, 16'h0404, 1'b0);
        req = 4'b0100;
        nc();
        req = '0;
        wait_res(r_id, r_sum, r_cout);
        nc();
        req = 4'b1001;
        #1;
        chk("wrap_gnt3", gnt, 4'b1000);
        nc();
        req = '0;
        wait_res(r_id, r_sum, r_cout);
        chk("wrap_sum3", r_sum, 16'h1111);
        nc();
        req = 4'b1001;
        #1;
        chk("wrap_gnt0", gnt, 4'b0001);
        nc();
        req = '0;
        wait_res(r_id, r_sum, r_cout);
        chk("wrap_sum0", r_sum, 16'h0B0B);
        nc();

        // Reset during the second holding cycle
        req = 4'b0001;
        set_op(0, 16'h4000, 16'h0321, 1'b1);
        nc();
        req = '0;
        nc();
        rst = 1'b1;
        nc();
        rst = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_add_a", add_a, 0);
        chk("mid_add_b", add_b, 0);
        chk("mid_add_cin", add_cin, 0);
        chk("mid_res_sum", res_sum, 0);
        chk("mid_res_cout", res_cout, 0);
        chk("mid_res_id", res_id, 0);
        chk("mid_gnt", gnt, 0);
        for (int k = 0; k < SETTLE + 2; k++) begin
            chk("mid_no_valid", res_valid, 0);
            nc();
        end
        req = 4'b1010;
        #1;
        chk("mid_gnt_after", gnt, 4'b0010);
        nc();
        req = '0;
        wait_res(r_id, r_sum, r_cout);
        nc();

        // Operand change during the hold window is ignored
        req = 4'b0001;
        set_op(0, 16'h0100, 16'h0023, 1'b0);
        nc();
        req = '0;
        set_op(0, 16'hFFFF, 16'h7777, 1'b1);
        #1;
        chk("hold_add_a", add_a, 16'h0100);
        wait_res(r_id, r_sum, r_cout);
        chk("hold_sum", r_sum, 16'h0123);
        chk("hold_cout", r_cout, 0);
        nc();

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            rst    = ($urandom_range(0, 79) == 0);
            req    = NREQ'($urandom_range(0, 15));
            a_in   = {$urandom(), $urandom()};
            b_in   = {$urandom(), $urandom()};
            cin_in = NREQ'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) a_in = {NREQ{16'hFFFF}};
            nc();
        end
        rst = 1'b0;
        req = '0;
        repeat (SETTLE + 3) nc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
